uno_seq: RTL and testbench

Unary-op sequencer for the RAVEN PE. It accepts one div/exp/log request at a time over a valid/ready handshake and drives the variable-generator stage with the op code and operand. It then steps the shared MAC through a fixed-length Horner polynomial by issuing coefficient indices and enables, and returns the accumulated result over a second valid/ready handshake. It sits between the PE instruction front-end and the var-gen/MAC datapath, and owns that datapath whenever a unary op is in flight.

---
 rtl/uno_seq.sv | 152 +++++++++++++++
 tb/tb_uno_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uno_seq.sv
// Unary-op sequencer: drives var-gen and steps the MAC through a Horner polynomial.
// Optional abort port is enabled by defining UNO_SEQ_ABORT_EN.
module uno_seq #(
    parameter int MUL_BW   = 16,
    parameter int TERM_NUM = 8,
    parameter int TERM_BW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld_i,
    output logic              req_rdy_o,
    input  logic [1:0]        req_op_i,
    input  logic [MUL_BW-1:0] req_x_i,
    output logic [1:0]        gemm_uno_o,
    output logic [MUL_BW-1:0] var_x_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [TERM_BW-1:0] coef_idx_o,
    input  logic [MUL_BW-1:0] acc_i,
    output logic              rsp_vld_o,
    input  logic              rsp_rdy_i,
    output logic [MUL_BW-1:0] rsp_data_o,
    output logic              rsp_err_o,
`ifdef UNO_SEQ_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VAR,
        S_ITER,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [TERM_BW-1:0]  cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [MUL_BW-1:0]   x_q, x_d;
    logic [MUL_BW-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                vld_q, vld_d;
    logic                mac_clr;
    logic                mac_en;
    logic [TERM_BW-1:0]  idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        data_d  = data_q;
        err_d   = err_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        idx     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req_vld_i) begin
                    op_d = req_op_i;
                    x_d  = req_x_i;
                    if (req_op_i == 2'b00) begin
                        // gemm is not a unary op: answer with an error, leave the MAC alone
                        state_d = S_RESP;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_VAR;
                    end
                end
            end
            S_VAR: begin
                mac_clr = 1'b1;
                cnt_d   = TERM_BW'(TERM_NUM - 1);
                state_d = S_ITER;
            end
            S_ITER: begin
                mac_en = 1'b1;
                idx    = cnt_q;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - TERM_BW'(1);
                end
            end
            S_DRAIN: begin
                data_d  = acc_i;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_rdy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UNO_SEQ_ABORT_EN
        // Abort beats everything in the MAC-owning states, including the last term
        if (abort_i && (state_q == S_VAR || state_q == S_ITER ||
                        state_q == S_DRAIN)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            data_d  = data_q;
            err_d   = err_q;
            mac_clr = 1'b1;
            mac_en  = 1'b0;
            idx     = '0;
        end
`endif

        vld_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            data_q  <= data_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign req_rdy_o  = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign gemm_uno_o = op_q;
    assign var_x_o    = x_q;
    assign mac_clr_o  = mac_clr;
    assign mac_en_o   = mac_en;
    assign coef_idx_o = idx;
    assign rsp_vld_o  = vld_q;
    assign rsp_data_o = data_q;
    assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq with hand-computed expectations.
module tb_uno_seq;

    logic        clk;
    logic        rst_n;
    logic        req_vld_i;
    logic        req_rdy_o;
    logic [1:0]  req_op_i;
    logic [15:0] req_x_i;
    logic [1:0]  gemm_uno_o;
    logic [15:0] var_x_o;
    logic        mac_clr_o;
    logic        mac_en_o;
    logic [2:0]  coef_idx_o;
    logic [15:0] acc_i;
    logic        rsp_vld_o;
    logic        rsp_rdy_i;
    logic [15:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    uno_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld_i  (req_vld_i),
        .req_rdy_o  (req_rdy_o),
        .req_op_i   (req_op_i),
        .req_x_i    (req_x_i),
        .gemm_uno_o (gemm_uno_o),
        .var_x_o    (var_x_o),
        .mac_clr_o  (mac_clr_o),
        .mac_en_o   (mac_en_o),
        .coef_idx_o (coef_idx_o),
        .acc_i      (acc_i),
        .rsp_vld_o  (rsp_vld_o),
        .rsp_rdy_i  (rsp_rdy_i),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one request for a single cycle; returns in cycle 1
    task automatic accept(input logic [1:0] op, input logic [15:0] x);
        req_vld_i = 1'b1;
        req_op_i  = op;
        req_x_i   = x;
        tick();
        req_vld_i = 1'b0;
    endtask

    task automatic wait_vld(input string tag, output int cyc);
        cyc = 0;
        while (!rsp_vld_o && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!rsp_vld_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  32'(req_rdy_o),  32'd1);
        chk({tag, "_busy"}, 32'(busy_o),     32'd0);
        chk({tag, "_vld"},  32'(rsp_vld_o),  32'd0);
        chk({tag, "_data"}, 32'(rsp_data_o), 32'd0);
        chk({tag, "_err"},  32'(rsp_err_o),  32'd0);
        chk({tag, "_clr"},  32'(mac_clr_o),  32'd0);
        chk({tag, "_en"},   32'(mac_en_o),   32'd0);
        chk({tag, "_idx"},  32'(coef_idx_o), 32'd0);
        chk({tag, "_op"},   32'(gemm_uno_o), 32'd0);
        chk({tag, "_x"},    32'(var_x_o),    32'd0);
    endtask

    initial begin
        int cyc;
        int en_cnt;
        int clr_cnt;
        rst_n     = 1'b0;
        req_vld_i = 1'b0;
        req_op_i  = 2'b00;
        req_x_i   = '0;
        acc_i     = '0;
        rsp_rdy_i = 1'b1;
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // div, full latency walk
        acc_i = 16'h1234;
        accept(2'b01, 16'h0C00);
        chk("div_c1_rdy",  32'(req_rdy_o),  32'd0);
        chk("div_c1_clr",  32'(mac_clr_o),  32'd1);
        chk("div_c1_en",   32'(mac_en_o),   32'd0);
        chk("div_c1_busy", 32'(busy_o),     32'd1);
        chk("div_op",      32'(gemm_uno_o), 32'd1);
        chk("div_x",       32'(var_x_o),    32'h0C00);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("div_en%0d", i),  32'(mac_en_o),   32'd1);
            chk($sformatf("div_idx%0d", i), 32'(coef_idx_o), 32'(7 - i));
            chk($sformatf("div_clr%0d", i), 32'(mac_clr_o),  32'd0);
        end
        tick();
        chk("div_c10_en",  32'(mac_en_o),  32'd0);
        chk("div_c10_vld", 32'(rsp_vld_o), 32'd0);
        tick();
        chk("div_c11_vld",  32'(rsp_vld_o),  32'd1);
        chk("div_c11_data", 32'(rsp_data_o), 32'h1234);
        chk("div_c11_err",  32'(rsp_err_o),  32'd0);
        tick();
        chk("div_c12_vld", 32'(rsp_vld_o), 32'd0);
        chk("div_c12_rdy", 32'(req_rdy_o), 32'd1);
        chk("div_hold_x",  32'(var_x_o),   32'h0C00);

        // exp with response back-pressure, second request held off
        rsp_rdy_i = 1'b0;
        acc_i = 16'hABCD;
        accept(2'b10, 16'h0100);
        wait_vld("exp", cyc);
        chk("exp_lat", 32'(cyc), 32'd10);
        chk("exp_data", 32'(rsp_data_o), 32'hABCD);
        acc_i     = 16'h0042;
        req_vld_i = 1'b1;
        req_op_i  = 2'b01;
        req_x_i   = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_vld%0d", i),  32'(rsp_vld_o),  32'd1);
            chk($sformatf("bp_data%0d", i), 32'(rsp_data_o), 32'hABCD);
            chk($sformatf("bp_busy%0d", i), 32'(busy_o),     32'd1);
            chk($sformatf("bp_rdy%0d", i),  32'(req_rdy_o),  32'd0);
        end
        rsp_rdy_i = 1'b1;
        tick();
        chk("bp_rel_rdy", 32'(req_rdy_o), 32'd1);
        chk("bp_rel_vld", 32'(rsp_vld_o), 32'd0);
        tick();
        req_vld_i = 1'b0;
        chk("bp2_clr", 32'(mac_clr_o),  32'd1);
        chk("bp2_op",  32'(gemm_uno_o), 32'd1);
        chk("bp2_x",   32'(var_x_o),    32'h0200);
        wait_vld("bp2", cyc);
        chk("bp2_data", 32'(rsp_data_o), 32'h0042);
        tick();

        // op 00: immediate error response, no MAC activity
        en_cnt  = 0;
        clr_cnt = 0;
        acc_i   = 16'h7777;
        accept(2'b00, 16'h1111);
        chk("g_vld",  32'(rsp_vld_o),  32'd1);
        chk("g_data", 32'(rsp_data_o), 32'd0);
        chk("g_err",  32'(rsp_err_o),  32'd1);
        chk("g_x",    32'(var_x_o),    32'h1111);
        for (int i = 0; i < 4; i++) begin
            en_cnt  += int'(mac_en_o);
            clr_cnt += int'(mac_clr_o);
            tick();
        end
        chk("g_en_cnt",  32'(en_cnt),  32'd0);
        chk("g_clr_cnt", 32'(clr_cnt), 32'd0);
        chk("g_done_vld", 32'(rsp_vld_o), 32'd0);

        // back-to-back log then div with requests held valid
        req_vld_i = 1'b1;
        req_op_i  = 2'b11;
        req_x_i   = 16'h0300;
        tick();
        chk("b2b_op1", 32'(gemm_uno_o), 32'd3);
        req_op_i = 2'b01;
        req_x_i  = 16'h0400;
        cyc = 1;
        while (!req_rdy_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("b2b_gap", 32'(cyc), 32'd12);
        tick();
        req_vld_i = 1'b0;
        chk("b2b_op2", 32'(gemm_uno_o), 32'd1);
        chk("b2b_x2",  32'(var_x_o),    32'h0400);
        wait_vld("b2b", cyc);
        chk("b2b_lat", 32'(cyc), 32'd10);
        tick();

        // asynchronous reset in the middle of ITER
        accept(2'b10, 16'h0500);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_en", 32'(mac_en_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cyc += int'(rsp_vld_o) + int'(mac_en_o);
        end
        chk("arst_quiet", 32'(cyc), 32'd0);
        acc_i = 16'h00FF;
        accept(2'b01, 16'h0600);
        wait_vld("post", cyc);
        chk("post_lat",  32'(cyc),        32'd10);
        chk("post_data", 32'(rsp_data_o), 32'h00FF);
        chk("post_err",  32'(rsp_err_o),  32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
